// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage RV32I pipeline, with load-use hazard stall/bubble and EX flush.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN; otherwise bubble_cnt is tied to 0.
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_5,
  input  logic             id_Branch,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_ALUSrc,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic [1:0]       id_ALUOp,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7_5,
  output logic             ex_Branch,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_ALUSrc,
  output logic             ex_RegWrite,
  output logic             ex_MemtoReg,
  output logic [1:0]       ex_ALUOp,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            branch;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic            memto_reg;
    logic [1:0]      alu_op;
  } stage_t;

  // Valid semantics: there is no ready from EX, the register advances every cycle.
  // id_valid/ex_valid only mark a slot as a real instruction; a bubble is valid=0 with
  // zeroed ctrl, and downstream must qualify every side effect with ex_valid.
  stage_t id_s;
  stage_t ex_q;
  stage_t ex_d;
  logic   valid_q;
  logic   valid_d;
  logic   hz;
  logic   load_bubble;

  always_comb begin
    id_s.pc        = id_pc;
    id_s.rs1_data  = id_rs1_data;
    id_s.rs2_data  = id_rs2_data;
    id_s.imm       = id_imm;
    id_s.rs1       = id_rs1;
    id_s.rs2       = id_rs2;
    id_s.rd        = id_rd;
    id_s.funct3    = id_funct3;
    id_s.funct7_5  = id_funct7_5;
    id_s.branch    = id_Branch;
    id_s.mem_read  = id_MemRead;
    id_s.mem_write = id_MemWrite;
    id_s.alu_src   = id_ALUSrc;
    id_s.reg_write = id_RegWrite;
    id_s.memto_reg = id_MemtoReg;
    id_s.alu_op    = id_ALUOp;
  end

  // Both source indices are compared for every opcode; a false stall only costs a cycle.
  assign hz = id_valid & valid_q & ex_q.mem_read & (ex_q.rd != 5'd0) &
              ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

  assign stall       = hz & ~flush;
  assign load_bubble = flush | hz;

  always_comb begin
    ex_d    = '0;
    valid_d = 1'b0;
    if (!load_bubble) begin
      ex_d    = id_s;
      valid_d = id_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_q;

  // Counts hazard bubbles only; flush bubbles are not load-use stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else if (stall && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  assign bubble_cnt = '0;
`endif

  assign ex_valid    = valid_q;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_funct3   = ex_q.funct3;
  assign ex_funct7_5 = ex_q.funct7_5;
  assign ex_Branch   = ex_q.branch;
  assign ex_MemRead  = ex_q.mem_read;
  assign ex_MemWrite = ex_q.mem_write;
  assign ex_ALUSrc   = ex_q.alu_src;
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_MemtoReg = ex_q.memto_reg;
  assign ex_ALUOp    = ex_q.alu_op;

endmodule
